// File: rtl/uart_cmd_wrapper.sv
// uart_cmd_wrapper: glue between a byte-oriented UART and a 16-bit command
// processor.
//
// Receive path: the high byte is assembled first, then the low byte. The result
// is presented as cmd/cmd_rdy and held until the processor pulses clr_cmd_rdy.
// Transmit path: response bytes go to the UART transmitter. One extra byte is
// buffered while a transmission is in flight.
//
// Optional feature: `define CMD_TIMEOUT_EN to enable it. When enabled, a high
// byte is discarded if the low byte does not arrive within TO_CYCLES clocks.
// When it is undefined, no counter is built and TO_CYCLES has no effect.
//
// Ports:
//   clk, rst_n    clock and asynchronous active-low reset
//   rx_data       byte from the UART receiver, valid while rx_rdy is high
//   rx_rdy        receiver holds the byte until clr_rx_rdy
//   clr_rx_rdy    one-cycle pulse; the byte has been consumed
//   cmd           assembled command {high byte, low byte}
//   cmd_rdy       cmd is valid and stable
//   clr_cmd_rdy   processor has finished with cmd
//   resp          response byte from the processor
//   send_resp     one-cycle request to transmit resp
//   resp_sent     one-cycle pulse; a response byte has finished transmitting
//   tx_data       byte to the UART transmitter
//   trmt          one-cycle pulse; start transmitting tx_data
//   tx_done       one-cycle pulse from the transmitter; the byte is finished
module uart_cmd_wrapper #(
    parameter logic [23:0] TO_CYCLES = 24'd1_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_rdy,
    output logic        clr_rx_rdy,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        send_resp,
    output logic        resp_sent,
    output logic [7:0]  tx_data,
    output logic        trmt,
    input  logic        tx_done
);

    localparam int unsigned TO_W = 24;

    typedef enum logic [1:0] {
        WAIT_HI   = 2'd0,
        WAIT_LO   = 2'd1,
        CMD_VALID = 2'd2
    } rx_state_t;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_BUSY = 1'b1
    } tx_state_t;

    rx_state_t  rx_state;
    tx_state_t  tx_state;
    logic       pend_vld;
    logic [7:0] pend_data;
    logic       rx_take;
    logic       to_expire;

    // clr_rx_rdy is registered, so the receiver still shows the old byte for
    // one cycle after it is consumed. Blocking capture in that cycle prevents
    // the same byte from being taken twice.
    assign rx_take = rx_rdy && !clr_rx_rdy;

`ifdef CMD_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt;

    // The counter is zero outside WAIT_LO, so it is always clear when WAIT_LO is entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (rx_state != WAIT_LO) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end

    assign to_expire = (rx_state == WAIT_LO) && !rx_take &&
                       (to_cnt == (TO_CYCLES - TO_W'(1)));
`else
    assign to_expire = 1'b0;
`endif

    // Receive FSM: assembles the two command bytes and holds the command until it is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state   <= WAIT_HI;
            cmd        <= 16'h0000;
            cmd_rdy    <= 1'b0;
            clr_rx_rdy <= 1'b0;
        end else begin
            clr_rx_rdy <= 1'b0;
            case (rx_state)
                WAIT_HI: begin
                    if (rx_take) begin
                        cmd[15:8]  <= rx_data;
                        clr_rx_rdy <= 1'b1;
                        rx_state   <= WAIT_LO;
                    end
                end
                WAIT_LO: begin
                    if (rx_take) begin
                        cmd[7:0]   <= rx_data;
                        clr_rx_rdy <= 1'b1;
                        cmd_rdy    <= 1'b1;
                        rx_state   <= CMD_VALID;
                    end else if (to_expire) begin
                        cmd[15:8]  <= 8'h00;
                        rx_state   <= WAIT_HI;
                    end
                end
                CMD_VALID: begin
                    // The receiver is back-pressured here; new bytes wait on rx_rdy.
                    if (clr_cmd_rdy) begin
                        cmd_rdy  <= 1'b0;
                        rx_state <= WAIT_HI;
                    end
                end
                default: begin
                    rx_state <= WAIT_HI;
                end
            endcase
        end
    end

    // Transmit FSM: keeps one byte in flight and one byte pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state  <= TX_IDLE;
            tx_data   <= 8'h00;
            trmt      <= 1'b0;
            resp_sent <= 1'b0;
            pend_vld  <= 1'b0;
            pend_data <= 8'h00;
        end else begin
            trmt      <= 1'b0;
            resp_sent <= 1'b0;
            case (tx_state)
                TX_IDLE: begin
                    // A stray tx_done while idle is ignored.
                    if (send_resp) begin
                        tx_data  <= resp;
                        trmt     <= 1'b1;
                        tx_state <= TX_BUSY;
                    end
                end
                TX_BUSY: begin
                    if (tx_done) begin
                        resp_sent <= 1'b1;
                        if (pend_vld) begin
                            // The pending byte goes out next; a request in the
                            // same cycle takes the freed pending slot.
                            tx_data  <= pend_data;
                            trmt     <= 1'b1;
                            pend_vld <= send_resp;
                            if (send_resp) begin
                                pend_data <= resp;
                            end
                        end else if (send_resp) begin
                            // Nothing is queued, so the new byte is sent directly.
                            tx_data <= resp;
                            trmt    <= 1'b1;
                        end else begin
                            tx_state <= TX_IDLE;
                        end
                    end else if (send_resp && !pend_vld) begin
                        pend_data <= resp;
                        pend_vld  <= 1'b1;
                    end
                end
                default: begin
                    tx_state <= TX_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// Scoreboard bench for uart_cmd_wrapper: expected commands and transmitted
// bytes are queued as stimulus is driven and compared when the DUT emits them.
module tb_uart_cmd_wrapper;

    localparam logic [23:0] TO_TB = 24'd16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_rdy = 1'b0;
    logic        clr_rx_rdy;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy = 1'b0;
    logic [7:0]  resp = 8'h00;
    logic        send_resp = 1'b0;
    logic        resp_sent;
    logic [7:0]  tx_data;
    logic        trmt;
    logic        tx_done;
    logic        tx_done_auto = 1'b0;
    logic        tx_done_man = 1'b0;
    bit          tx_auto = 1'b1;

    assign tx_done = tx_done_auto | tx_done_man;

    always #5 clk = ~clk;

    uart_cmd_wrapper #(.TO_CYCLES(TO_TB)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .rx_rdy      (rx_rdy),
        .clr_rx_rdy  (clr_rx_rdy),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .resp        (resp),
        .send_resp   (send_resp),
        .resp_sent   (resp_sent),
        .tx_data     (tx_data),
        .trmt        (trmt),
        .tx_done     (tx_done)
    );

    int n_vec = 0;
    int n_err = 0;
    int n_clr = 0;
    int n_trmt = 0;
    int n_resp = 0;
    logic [15:0] sb_cmd[$];
    logic [7:0]  sb_tx[$];

    logic        cmd_rdy_q = 1'b0;
    logic [15:0] cmd_q = 16'h0000;
    logic        clr_q = 1'b0;
    logic        trmt_q = 1'b0;
    logic        resp_q = 1'b0;
    logic        done_q = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    always @(posedge clk) done_q <= tx_done;

    // Output monitor: pops the scoreboards and checks the single-cycle pulse rules.
    always @(negedge clk) begin
        if (!rst_n) begin
            cmd_rdy_q <= 1'b0;
            clr_q     <= 1'b0;
            trmt_q    <= 1'b0;
            resp_q    <= 1'b0;
        end else begin
            if (cmd_rdy && !cmd_rdy_q) begin
                check_eq("cmd_sb_depth", 32'(sb_cmd.size() != 0), 32'd1);
                if (sb_cmd.size() != 0) check_eq("cmd", 32'(cmd), 32'(sb_cmd.pop_front()));
            end
            if (cmd_rdy && cmd_rdy_q) check_eq("cmd_stable", 32'(cmd), 32'(cmd_q));
            if (clr_rx_rdy) begin
                n_clr++;
                check_eq("clr_width", 32'(clr_q), 32'd0);
            end
            if (trmt) begin
                n_trmt++;
                check_eq("trmt_width", 32'(trmt_q), 32'd0);
                check_eq("tx_sb_depth", 32'(sb_tx.size() != 0), 32'd1);
                if (sb_tx.size() != 0) check_eq("tx_data", 32'(tx_data), 32'(sb_tx.pop_front()));
            end
            if (resp_sent) begin
                n_resp++;
                check_eq("resp_width", 32'(resp_q), 32'd0);
                check_eq("resp_after_done", 32'(done_q), 32'd1);
            end
            cmd_rdy_q <= cmd_rdy;
            cmd_q     <= cmd;
            clr_q     <= clr_rx_rdy;
            trmt_q    <= trmt;
            resp_q    <= resp_sent;
        end
    end

    // Transmitter model: finishes each byte three cycles after trmt.
    initial begin
        forever begin
            if (tx_auto && rst_n && trmt) begin
                repeat (3) @(negedge clk);
                tx_done_auto = 1'b1;
                @(negedge clk);
                tx_done_auto = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Receiver model: hold the byte until clr_rx_rdy is seen, then drop rx_rdy.
    task automatic rx_push(input logic [7:0] b);
        bit seen;
        seen = 1'b0;
        rx_data = b;
        rx_rdy = 1'b1;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (clr_rx_rdy) begin
                seen = 1'b1;
                rx_rdy = 1'b0;
            end
        end
        check_eq("rx_consumed", 32'(seen), 32'd1);
        rx_rdy = 1'b0;
        @(negedge clk);
        check_eq("clr_pulse_end", 32'(clr_rx_rdy), 32'd0);
    endtask

    task automatic wait_cmd();
        for (int i = 0; i < 40 && !cmd_rdy; i++) @(negedge clk);
        check_eq("cmd_rdy_wait", 32'(cmd_rdy), 32'd1);
    endtask

    task automatic clr_cmd();
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        check_eq("cmd_rdy_clear", 32'(cmd_rdy), 32'd0);
    endtask

    task automatic send(input logic [7:0] b, input bit expect_tx);
        if (expect_tx) sb_tx.push_back(b);
        resp = b;
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
    endtask

    initial begin
        int  base_clr;
        int  base_resp;
        int  base_trmt;
        bit  seen;
        bit  bad;
        logic [7:0] hi;
        logic [7:0] lo;

        // Reset values
        tick(2);
        check_eq("rst_cmd", 32'(cmd), 32'h0);
        check_eq("rst_cmd_rdy", 32'(cmd_rdy), 32'd0);
        check_eq("rst_clr_rx_rdy", 32'(clr_rx_rdy), 32'd0);
        check_eq("rst_tx_data", 32'(tx_data), 32'h0);
        check_eq("rst_trmt", 32'(trmt), 32'd0);
        check_eq("rst_resp_sent", 32'(resp_sent), 32'd0);
        rst_n = 1'b1;
        tick(2);

        // Basic command assembly
        base_clr = n_clr;
        sb_cmd.push_back(16'h410A);
        rx_push(8'h41);
        rx_push(8'h0A);
        wait_cmd();
        tick(4);
        check_eq("cmd_held", 32'(cmd_rdy), 32'd1);
        check_eq("clr_count", 32'(n_clr - base_clr), 32'd2);
        clr_cmd();

        // clr_cmd_rdy is ignored in WAIT_HI and WAIT_LO
        clr_cmd();
        sb_cmd.push_back(16'h1234);
        rx_push(8'h12);
        clr_cmd_rdy = 1'b1;
        tick(1);
        clr_cmd_rdy = 1'b0;
        rx_push(8'h34);
        wait_cmd();

        // Backpressure while a command is valid
        sb_cmd.push_back(16'h8055);
        rx_data = 8'h80;
        rx_rdy = 1'b1;
        bad = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (clr_rx_rdy) bad = 1'b1;
        end
        check_eq("rx_backpressure", 32'(bad), 32'd0);
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        check_eq("cmd_rdy_clear2", 32'(cmd_rdy), 32'd0);
        check_eq("no_take_on_clr", 32'(clr_rx_rdy), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (clr_rx_rdy) begin
                seen = 1'b1;
                rx_rdy = 1'b0;
            end
        end
        check_eq("pending_taken", 32'(seen), 32'd1);
        @(negedge clk);
        rx_push(8'h55);
        wait_cmd();
        clr_cmd();

        // Random commands
        for (int k = 0; k < 4; k++) begin
            hi = 8'($urandom_range(0, 255));
            lo = 8'($urandom_range(0, 255));
            sb_cmd.push_back({hi, lo});
            rx_push(hi);
            rx_push(lo);
            wait_cmd();
            clr_cmd();
        end

        // Idle-state timeout behaviour
`ifdef CMD_TIMEOUT_EN
        rx_push(8'h7F);
        tick(20);
        check_eq("to_no_cmd", 32'(cmd_rdy), 32'd0);
        sb_cmd.push_back(16'h0102);
        rx_push(8'h01);
        rx_push(8'h02);
        wait_cmd();
        clr_cmd();
`else
        sb_cmd.push_back(16'h7F01);
        rx_push(8'h7F);
        tick(20);
        check_eq("lo_wait_no_cmd", 32'(cmd_rdy), 32'd0);
        rx_push(8'h01);
        wait_cmd();
        clr_cmd();
`endif

        // Single response, with one cycle of latency
        base_resp = n_resp;
        sb_tx.push_back(8'hA5);
        resp = 8'hA5;
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
        check_eq("trmt_latency", 32'(trmt), 32'd1);
        check_eq("tx_data_a5", 32'(tx_data), 32'hA5);
        tick(8);
        check_eq("resp_cnt_1", 32'(n_resp - base_resp), 32'd1);

        // Three requests while busy: the third byte is dropped
        base_resp = n_resp;
        base_trmt = n_trmt;
        send(8'h11, 1'b1);
        send(8'h22, 1'b1);
        send(8'h33, 1'b0);
        tick(16);
        check_eq("resp_cnt_2", 32'(n_resp - base_resp), 32'd2);
        check_eq("trmt_cnt_2", 32'(n_trmt - base_trmt), 32'd2);

        // tx_done while idle, then send_resp in the same cycle as tx_done
        tx_auto = 1'b0;
        tx_done_man = 1'b1;
        @(negedge clk);
        tx_done_man = 1'b0;
        @(negedge clk);
        check_eq("idle_done_ignored", 32'(resp_sent), 32'd0);
        send(8'h61, 1'b1);
        send(8'h62, 1'b1);
        tick(1);
        sb_tx.push_back(8'h63);
        tx_done_man = 1'b1;
        resp = 8'h63;
        send_resp = 1'b1;
        @(negedge clk);
        tx_done_man = 1'b0;
        send_resp = 1'b0;
        check_eq("sim_trmt", 32'(trmt), 32'd1);
        check_eq("sim_pend_out", 32'(tx_data), 32'h62);
        check_eq("sim_resp", 32'(resp_sent), 32'd1);
        tick(1);
        tx_done_man = 1'b1;
        @(negedge clk);
        tx_done_man = 1'b0;
        check_eq("sim_new_out", 32'(tx_data), 32'h63);
        tick(1);
        tx_done_man = 1'b1;
        @(negedge clk);
        tx_done_man = 1'b0;
        check_eq("last_resp", 32'(resp_sent), 32'd1);
        check_eq("last_no_trmt", 32'(trmt), 32'd0);
        tick(2);

        // Reset during a partial command and a busy transmitter with a pending byte
        rx_push(8'h99);
        send(8'h71, 1'b1);
        send(8'h72, 1'b0);
        tick(1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_cmd", 32'(cmd), 32'h0);
        check_eq("mid_rst_cmd_rdy", 32'(cmd_rdy), 32'd0);
        check_eq("mid_rst_clr", 32'(clr_rx_rdy), 32'd0);
        check_eq("mid_rst_tx_data", 32'(tx_data), 32'h0);
        check_eq("mid_rst_trmt", 32'(trmt), 32'd0);
        check_eq("mid_rst_resp", 32'(resp_sent), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tx_done_man = 1'b1;
        @(negedge clk);
        tx_done_man = 1'b0;
        bad = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (trmt || resp_sent) bad = 1'b1;
        end
        check_eq("post_rst_quiet", 32'(bad), 32'd0);
        sb_cmd.push_back(16'h0102);
        rx_push(8'h01);
        rx_push(8'h02);
        wait_cmd();
        clr_cmd();
        tx_auto = 1'b1;
        base_resp = n_resp;
        send(8'h5A, 1'b1);
        tick(10);
        check_eq("post_rst_resp", 32'(n_resp - base_resp), 32'd1);

        tick(4);
        check_eq("sb_cmd_left", 32'(sb_cmd.size()), 32'd0);
        check_eq("sb_tx_left", 32'(sb_tx.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_cmd_wrapper.md
UART_CMD_WRAPPER -- requirements
Module: uart_cmd_wrapper

Interface
REQ-001 Parameter TO_CYCLES, default 24'd1_000_000, clocks allowed between command high byte and low byte before the high byte is discarded.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 rx_data  input  8  byte from UART receiver; valid while rx_rdy=1.
REQ-005 rx_rdy  input  1  level; receiver holds a byte until cleared.
REQ-006 clr_rx_rdy  output  1  one-cycle pulse; byte on rx_data consumed.
REQ-007 cmd  output  16  assembled command, {first byte, second byte}.
REQ-008 cmd_rdy  output  1  level; cmd valid and stable.
REQ-009 clr_cmd_rdy  input  1  pulse from command processor; command finished.
REQ-010 resp  input  8  response byte from command processor.
REQ-011 send_resp  input  1  one-cycle pulse; transmit resp.
REQ-012 resp_sent  output  1  one-cycle pulse; a response byte finished transmitting.
REQ-013 tx_data  output  8  byte to UART transmitter.
REQ-014 trmt  output  1  one-cycle pulse; start transmitting tx_data.
REQ-015 tx_done  input  1  one-cycle pulse from transmitter; byte finished.

Function
REQ-016 Receive FSM states SHALL be WAIT_HI, WAIT_LO, CMD_VALID.
REQ-017 WAIT_HI with rx_rdy=1: cmd[15:8]<=rx_data, clr_rx_rdy pulsed in the same cycle, next state WAIT_LO.
REQ-018 WAIT_LO with rx_rdy=1: cmd[7:0]<=rx_data, clr_rx_rdy pulsed, cmd_rdy=1 on the following cycle, next state CMD_VALID.
REQ-019 CMD_VALID: cmd and cmd_rdy held stable; rx_rdy ignored (clr_rx_rdy not pulsed; receiver provides backpressure).
REQ-020 CMD_VALID with clr_cmd_rdy=1: cmd_rdy=0 next cycle, next state WAIT_HI; a byte pending on rx_rdy that cycle is not consumed until the next cycle.
REQ-021 clr_cmd_rdy outside CMD_VALID SHALL be ignored.
REQ-022 Transmit path states SHALL be TX_IDLE, TX_BUSY, plus a one-entry pending register (pend_vld, pend_data).
REQ-023 TX_IDLE with send_resp: tx_data<=resp, trmt=1 on the next cycle, next state TX_BUSY; latency send_resp to trmt is exactly 1 clock.
REQ-024 TX_BUSY with tx_done: resp_sent=1 on the next cycle; if pend_vld, tx_data<=pend_data, trmt=1, pend_vld cleared, stay TX_BUSY; else go TX_IDLE.
REQ-025 TX_BUSY with send_resp and pend_vld=0: pend_data<=resp, pend_vld<=1.
REQ-026 TX_BUSY with send_resp and pend_vld=1: new byte dropped; pending byte unchanged.
REQ-027 TX_BUSY with send_resp and tx_done in the same cycle: pending byte (if any) transmitted next, new resp captured into the pending register.
REQ-028 tx_done in TX_IDLE SHALL be ignored (no resp_sent).
REQ-029 trmt and resp_sent SHALL never be high for more than one consecutive cycle per byte.
REQ-030 Receive and transmit paths SHALL operate independently; command reception continues while a response is in flight.

Reset
REQ-031 On rst_n=0, asynchronously: receive FSM=WAIT_HI, transmit FSM=TX_IDLE, cmd=16'h0000, cmd_rdy=0, clr_rx_rdy=0, tx_data=8'h00, trmt=0, resp_sent=0, pend_vld=0, timeout counter=0.
REQ-032 Reset mid-command or mid-transmission SHALL discard the partial command and any pending byte; no trmt or resp_sent is issued after release until a new send_resp.

Configuration
REQ-033 Macro CMD_TIMEOUT_EN defined: a counter clears on entry to WAIT_LO and increments each cycle in WAIT_LO; on reaching TO_CYCLES-1 without rx_rdy, the FSM returns to WAIT_HI and cmd[15:8] is discarded (cmd_rdy never asserted).
REQ-034 CMD_TIMEOUT_EN undefined: no counter is built; WAIT_LO waits indefinitely; TO_CYCLES is unused.

Verification
REQ-035 Bytes 8'h41 then 8'h0A on rx -> two clr_rx_rdy pulses, cmd=16'h410A, cmd_rdy=1 until clr_cmd_rdy, then 0 next cycle.
REQ-036 cmd_rdy=1 and byte 8'h80 arrives -> no clr_rx_rdy until after clr_cmd_rdy; then 8'h80 captured as cmd[15:8].
REQ-037 send_resp with resp=8'hA5 -> trmt one cycle later with tx_data=8'hA5; tx_done -> resp_sent next cycle.
REQ-038 send_resp 8'h11, 8'h22, 8'h33 while busy -> 8'h11 then 8'h22 transmitted, 8'h33 dropped, two resp_sent pulses after the two tx_done pulses.
REQ-039 CMD_TIMEOUT_EN, TO_CYCLES=16: byte 8'h7F then silence 20 clocks, then bytes 8'h01, 8'h02 -> cmd=16'h0102.
REQ-040 rst_n asserted during TX_BUSY with pend_vld=1 -> all outputs at reset values; subsequent tx_done produces no resp_sent.
